// File: rtl/williams2_rom_loader.sv
// Williams 2 ROM download loader.
// Accepts HPS ioctl download bytes for the selected index, decodes the byte
// address into CPU / sound / graphics ROM regions and issues one handshaked
// write per byte, holding ioctl_wait high until the write is acknowledged or
// times out. Tracks a running checksum plus done/error status.
//
// Ports:
//   clk_sys, reset_n                  clock, async active-low reset
//   ioctl_download/index/wr/addr/dout HPS download interface (in)
//   ioctl_wait                        back-pressure to HPS (out)
//   mem_req/mem_sel/mem_addr/mem_data ROM write request (out), mem_ack (in)
//   loading, load_done, load_error    download status (out)
//   checksum                          16-bit wrapping sum of accepted bytes
module williams2_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [16:0] SND_BASE    = 17'h10000,
  parameter logic [16:0] GFX_BASE    = 17'h18000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        loading,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_ACK} state_t;

  state_t      r_state;
  logic        r_active;
  logic [16:0] r_exp_addr;
  logic [7:0]  r_tmo;

  logic        w_active;
  logic        w_start;
  logic        w_accept;
  logic        w_overrun;
  logic        w_timeout;
  logic        w_write_end;
  logic        w_pending;
  logic        w_loading_nxt;
  logic [15:0] w_chk_base;
  logic [16:0] w_exp_base;
  logic [1:0]  w_sel;
  logic [15:0] w_maddr;

  assign w_active  = ioctl_download && (ioctl_index == ROM_INDEX);
  assign w_start   = w_active && !r_active;
  assign w_accept  = w_active && ioctl_wr && (r_state == S_IDLE);
  assign w_overrun = w_active && ioctl_wr && (r_state != S_IDLE);

  // Timeout fires on the ACK_TIMEOUT-th WAIT_ACK cycle without an ack.
  assign w_timeout   = (r_state == S_WAIT_ACK) && !mem_ack &&
                       (({1'b0, r_tmo} + 9'd1) >= {1'b0, ACK_TIMEOUT});
  assign w_write_end = (mem_req && mem_ack) || w_timeout;

  // A write is outstanding after this edge if one is accepted now or the
  // current one does not finish now; loading is held through it.
  assign w_pending     = w_accept || ((r_state != S_IDLE) && !w_write_end);
  assign w_loading_nxt = w_active || (loading && w_pending);

  // A strobe coincident with the start edge sees the cleared values.
  assign w_chk_base = w_start ? '0 : checksum;
  assign w_exp_base = w_start ? '0 : r_exp_addr;

  // Offsets are taken modulo 2^16, so only the low address bits matter.
  always_comb begin
    w_sel   = 2'd0;
    w_maddr = ioctl_addr[15:0];
    if (ioctl_addr >= GFX_BASE) begin
      w_sel   = 2'd2;
      w_maddr = ioctl_addr[15:0] - GFX_BASE[15:0];
    end else if (ioctl_addr >= SND_BASE) begin
      w_sel   = 2'd1;
      w_maddr = ioctl_addr[15:0] - SND_BASE[15:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_active   <= 1'b0;
      r_exp_addr <= '0;
      r_tmo      <= '0;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_sel    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      loading    <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      checksum   <= '0;
    end else begin
      r_active <= w_active;
      loading  <= w_loading_nxt;

      if (w_start)
        load_done <= 1'b0;
      else if (loading && !w_loading_nxt)
        load_done <= 1'b1;

      if (w_accept) begin
        checksum   <= w_chk_base + {8'd0, ioctl_dout};
        r_exp_addr <= ioctl_addr + 17'd1;
      end else if (w_start) begin
        checksum   <= '0;
        r_exp_addr <= '0;
      end

      if (w_overrun || w_timeout || (w_accept && (ioctl_addr != w_exp_base)))
        load_error <= 1'b1;
      else if (w_start)
        load_error <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_REQ;
            mem_req    <= 1'b1;
            ioctl_wait <= 1'b1;
            mem_sel    <= w_sel;
            mem_addr   <= w_maddr;
            mem_data   <= ioctl_dout;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state    <= S_IDLE;
            mem_req    <= 1'b0;
            ioctl_wait <= 1'b0;
          end else begin
            r_state <= S_WAIT_ACK;
            r_tmo   <= '0;
          end
        end
        S_WAIT_ACK: begin
          if (mem_ack || w_timeout) begin
            r_state    <= S_IDLE;
            mem_req    <= 1'b0;
            ioctl_wait <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          mem_req    <= 1'b0;
          ioctl_wait <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_williams2_rom_loader.sv
// Self-checking bench for williams2_rom_loader: a memory responder pops the
// expected {sel, addr, data} for each write from a queue filled when the
// strobe is driven, and acknowledges after a programmable latency.
module tb_williams2_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        loading;
  logic        load_done;
  logic        load_error;
  logic [15:0] checksum;

  always #5 clk_sys = ~clk_sys;

  williams2_rom_loader #(
    .ROM_INDEX  (8'd0),
    .SND_BASE   (17'h10000),
    .GFX_BASE   (17'h18000),
    .ACK_TIMEOUT(8'd255)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_sel       (mem_sel),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .loading       (loading),
    .load_done     (load_done),
    .load_error    (load_error),
    .checksum      (checksum)
  );

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int          lat;
    logic [1:0]  sel;
    logic [15:0] maddr;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  vec_t        vecs[10];
  exp_t        exp_q[$];
  exp_t        cur;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          ack_lat = 0;
  int          req_cyc = 0;
  int          last_req_len = 0;
  int          writes = 0;
  logic [15:0] model_sum;
  logic        saw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder / scoreboard.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      mem_ack = 1'b0;
      req_cyc = 0;
    end else if (mem_req) begin
      if (req_cyc == 0) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL sb_unexpected_req: got sel %0d addr %h data %h, required no request",
                   mem_sel, mem_addr, mem_data);
        end else begin
          cur = exp_q.pop_front();
          writes++;
          check("sb_sel", 32'(mem_sel), 32'(cur.sel));
          check("sb_addr", 32'(mem_addr), 32'(cur.addr));
          check("sb_data", 32'(mem_data), 32'(cur.data));
        end
      end
      if (ack_lat >= 0 && req_cyc == ack_lat) begin
        mem_ack = 1'b1;
        check("hold_addr", 32'(mem_addr), 32'(cur.addr));
        check("hold_data", 32'(mem_data), 32'(cur.data));
      end
      req_cyc++;
    end else begin
      mem_ack = 1'b0;
      if (req_cyc != 0) last_req_len = req_cyc;
      req_cyc = 0;
    end
  end

  // Called aligned at posedge+1; leaves the strobe high for exactly one edge.
  task automatic strobe(input logic [16:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] s, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.sel = s; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk_sys);
    while ((mem_req || ioctl_wait) && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    if (mem_req || ioctl_wait) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: write still pending after %0d cycles, required idle", name, n);
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic do_vec(input int i);
    ack_lat = vecs[i].lat;
    push_exp(vecs[i].sel, vecs[i].maddr, vecs[i].data);
    model_sum = model_sum + {8'd0, vecs[i].data};
    strobe(vecs[i].addr, vecs[i].data);
    wait_idle("vec_done");
  endtask

  task automatic start_dl();
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  initial begin
    vecs[0] = '{17'h00000, 8'h01, 2, 2'd0, 16'h0000};
    vecs[1] = '{17'h00001, 8'h02, 2, 2'd0, 16'h0001};
    vecs[2] = '{17'h00002, 8'h03, 2, 2'd0, 16'h0002};
    vecs[3] = '{17'h00003, 8'h04, 2, 2'd0, 16'h0003};
    vecs[4] = '{17'h10005, 8'hA5, 0, 2'd1, 16'h0005};
    vecs[5] = '{17'h18010, 8'h5A, 0, 2'd2, 16'h0010};
    vecs[6] = '{17'h0FFFF, 8'hFF, 1, 2'd0, 16'hFFFF};
    vecs[7] = '{17'h10000, 8'h80, 1, 2'd1, 16'h0000};
    vecs[8] = '{17'h17FFF, 8'h7F, 3, 2'd1, 16'h7FFF};
    vecs[9] = '{17'h1FFFF, 8'hC3, 0, 2'd2, 16'h7FFF};

    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_wait", 32'(ioctl_wait), 0);
    check("rst_loading", 32'(loading), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_error", 32'(load_error), 0);
    check("rst_checksum", 32'(checksum), 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    // Sequential CPU-region download.
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    check("loading_rise", 32'(loading), 1);
    model_sum = '0;
    for (int i = 0; i < 4; i++) begin
      do_vec(i);
      check("chk_run", 32'(checksum), 32'(model_sum));
    end
    check("seq_error", 32'(load_error), 0);
    check("done_while_loading", 32'(load_done), 0);
    check("seq_checksum", 32'(checksum), 32'h000A);
    end_dl();
    check("end_loading", 32'(loading), 0);
    check("end_done", 32'(load_done), 1);

    // Region decode and boundaries.
    start_dl();
    check("start_checksum", 32'(checksum), 0);
    check("start_done", 32'(load_done), 0);
    model_sum = '0;
    for (int i = 4; i < 10; i++) begin
      last_req_len = 0;
      do_vec(i);
      if (i == 4) begin
        check("req_len_ack0", 32'(last_req_len), 1);
        check("jump_error", 32'(load_error), 1);
      end
    end
    check("region_checksum", 32'(checksum), 32'(model_sum));

    // Overrun: second strobe while ioctl_wait is high.
    start_dl();
    check("start_error", 32'(load_error), 0);
    ack_lat = 5;
    push_exp(2'd0, 16'h0000, 8'h11);
    strobe(17'h00000, 8'h11);
    check("wait_high", 32'(ioctl_wait), 1);
    strobe(17'h00001, 8'h22);
    wait_idle("overrun_done");
    check("overrun_error", 32'(load_error), 1);
    check("overrun_checksum", 32'(checksum), 32'h0011);
    check("overrun_queue", 32'(exp_q.size()), 0);

    // Ack timeout, then recovery.
    start_dl();
    ack_lat = -1;
    last_req_len = 0;
    push_exp(2'd0, 16'h0000, 8'h33);
    strobe(17'h00000, 8'h33);
    wait_idle("timeout_done");
    check("timeout_req_len", 32'(last_req_len), 32'd256);
    check("timeout_error", 32'(load_error), 1);
    ack_lat = 1;
    last_req_len = 0;
    push_exp(2'd0, 16'h0001, 8'h44);
    strobe(17'h00001, 8'h44);
    wait_idle("after_timeout");
    check("after_to_req_len", 32'(last_req_len), 2);
    check("after_to_checksum", 32'(checksum), 32'h0077);
    check("error_sticky", 32'(load_error), 1);

    // loading held through a write pending when the download ends.
    ack_lat = 6;
    push_exp(2'd0, 16'h0002, 8'h55);
    strobe(17'h00002, 8'h55);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("loading_hold", 32'(loading), 1);
    check("done_hold", 32'(load_done), 0);
    wait_idle("hold_done");
    check("hold_loading_fall", 32'(loading), 0);
    check("hold_done_set", 32'(load_done), 1);

    // Non-matching index is ignored.
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check("idx1_loading", 32'(loading), 0);
    strobe(17'h00000, 8'h66);
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk_sys);
      if (mem_req || ioctl_wait) saw = 1'b1;
    end
    check("idx1_no_req", 32'(saw), 0);
    check("idx1_checksum", 32'(checksum), 32'h00CC);
    @(posedge clk_sys); #1;

    // Address sequence 0,1,3.
    ioctl_index = 8'd0;
    @(posedge clk_sys); #1;
    check("restart_checksum", 32'(checksum), 0);
    ack_lat = 1;
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      logic [16:0] a;
      a = (i == 2) ? 17'd3 : 17'(i);
      push_exp(2'd0, a[15:0], 8'(i + 1));
      strobe(a, 8'(i + 1));
      wait_idle("gap_write");
      if (i == 1) check("gap_no_error_yet", 32'(load_error), 0);
    end
    check("gap_error", 32'(load_error), 1);
    check("gap_checksum", 32'(checksum), 32'h0006);
    check("gap_writes", 32'(writes), 3);

    // Reset mid-WAIT_ACK.
    ack_lat = -1;
    push_exp(2'd0, 16'h0004, 8'h88);
    strobe(17'h00004, 8'h88);
    repeat (5) @(posedge clk_sys);
    #2;
    check("pre_rst_req", 32'(mem_req), 1);
    reset_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_wait", 32'(ioctl_wait), 0);
    check("arst_loading", 32'(loading), 0);
    check("arst_error", 32'(load_error), 0);
    check("arst_checksum", 32'(checksum), 0);
    check("arst_sel", 32'(mem_sel), 0);
    check("arst_addr", 32'(mem_addr), 0);
    check("arst_data", 32'(mem_data), 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk_sys);
      if (mem_req || ioctl_wait) saw = 1'b1;
    end
    check("post_rst_idle", 32'(saw), 0);
    @(posedge clk_sys); #1;
    ack_lat = 0;
    push_exp(2'd0, 16'h0000, 8'h99);
    strobe(17'h00000, 8'h99);
    wait_idle("post_rst_write");
    check("post_rst_checksum", 32'(checksum), 32'h0099);
    check("post_rst_error", 32'(load_error), 0);
    end_dl();
    check("final_done", 32'(load_done), 1);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
